// File: rtl/data_c_intc_pkg.sv
// Shared types and helpers for the data_c interconnect and its address scheduler.
package data_c_intc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    BUSY
  } STATUS;

  // Source index width for a given number of sources.
  function automatic int unsigned nsize(input int unsigned num);
    if (num <= 2) return 1;
    else if (num <= 4) return 2;
    else if (num <= 8) return 3;
    else if (num <= 16) return 4;
    else return 5;
  endfunction

endpackage

// File: rtl/data_c_intc_rr_addr_sched_if.sv
// Address handshake carrying the granted source index to the M2S pipe interconnect.
interface data_c_intc_rr_addr_sched_if #(
  parameter int unsigned NSIZE = 3
);
  logic             addr_valid;
  logic             addr_ready;
  logic [NSIZE-1:0] addr_data;

  modport master (output addr_valid, output addr_data, input addr_ready);
  modport slave (input addr_valid, input addr_data, output addr_ready);
endinterface

// File: rtl/data_c_rr_pick.sv
// Combinational round-robin pick: first set bit of cand searching upward from ptr+1 with wrap.
module data_c_rr_pick
  import data_c_intc_pkg::*;
#(
  parameter int unsigned NUM   = 8,
  parameter int unsigned NSIZE = nsize(NUM)
) (
  input  logic [NUM-1:0]   cand,
  input  logic [NSIZE-1:0] ptr,
  output logic [NSIZE-1:0] idx,
  output logic             hit
);

  logic [NSIZE-1:0] start;
  logic [2*NUM-1:0] dbl;
  logic [NUM-1:0]   rot;
  logic [NSIZE-1:0] off;
  logic [NSIZE:0]   sum;

  always_comb begin
    start = (ptr >= NSIZE'(NUM - 1)) ? '0 : ptr + 1'b1;
    dbl   = {cand, cand} >> start;
    rot   = dbl[NUM-1:0];
    // Descending scan so the lowest rotated position (closest to start) wins.
    off   = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (rot[i]) off = NSIZE'(i);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (NSIZE + 1)'(NUM)) sum = sum - (NSIZE + 1)'(NUM);
    idx = sum[NSIZE-1:0];
    hit = |cand;
  end

endmodule

// File: rtl/data_c_intc_rr_addr_sched.sv
// Round-robin owner scheduler for the shared M2S pipe: one index per packet plus a BUSY watchdog.
module data_c_intc_rr_addr_sched
  import data_c_intc_pkg::*;
#(
  parameter int unsigned NUM     = 8,
  parameter int unsigned NSIZE   = nsize(NUM),
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TSIZE   = $clog2(TIMEOUT + 1)
) (
  input  logic                                clock,
  input  logic                                rst,
  input  logic [NUM-1:0]                      req_vld,
  input  logic [NUM-1:0]                      req_en,
  input  logic                                pkt_done,
  data_c_intc_rr_addr_sched_if.master         addr,
  output logic                                busy,
  output logic                                timeout_err,
  input  logic                                err_clr
);

  localparam int unsigned CW    = (TSIZE < 1) ? 1 : TSIZE;
  localparam bit          WdEn  = (TIMEOUT != 0);
  localparam int unsigned TLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  STATUS            state_q, state_d;
  logic [NSIZE-1:0] ptr_q, ptr_d;
  logic [NSIZE-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [NSIZE-1:0] pick_idx;
  logic             pick_hit;

  data_c_rr_pick #(
    .NUM  (NUM),
    .NSIZE(NSIZE)
  ) u_pick (
    .cand(req_vld & req_en),
    .ptr (ptr_q),
    .idx (pick_idx),
    .hit (pick_hit)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (err_clr) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          data_d  = pick_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (addr.addr_ready) begin
          ptr_d   = data_q;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pkt_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (WdEn) begin
          if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
          // Set beats a simultaneous clear; the grant itself is never revoked.
          if (cnt_q == CW'(TLast)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= NSIZE'(NUM - 1);
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign addr.addr_valid = (state_q == OFFER);
  assign addr.addr_data  = data_q;
  assign busy            = (state_q == BUSY);
  assign timeout_err     = err_q;

endmodule

// File: tb/tb_data_c_intc_rr_addr_sched.sv
// Randomized and directed bench for the round-robin address scheduler against a behavioural model.
module tb_data_c_intc_rr_addr_sched;

  localparam int unsigned NUM = 8;
  localparam int unsigned NSZ = 3;
  localparam int unsigned TMO = 16;

  logic           clock = 1'b0;
  logic           rst;
  logic [NUM-1:0] req_vld;
  logic [NUM-1:0] req_en;
  logic           pkt_done;
  logic           busy;
  logic           timeout_err;
  logic           err_clr;

  data_c_intc_rr_addr_sched_if #(.NSIZE(NSZ)) addr_if ();

  data_c_intc_rr_addr_sched #(
    .NUM    (NUM),
    .TIMEOUT(TMO)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_en     (req_en),
    .pkt_done   (pkt_done),
    .addr       (addr_if),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: who is offered/owning, last index, rotation pointer, BUSY age, error flag.
  bit m_off, m_busy, m_err;
  int m_idx, m_ptr, m_age;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_search(input logic [NUM-1:0] cand, input int ptr);
    for (int k = 1; k <= NUM; k++) begin
      if (cand[(ptr + k) % NUM]) return (ptr + k) % NUM;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_off = 0; m_busy = 0; m_err = 0; m_idx = 0; m_ptr = NUM - 1; m_age = 0;
  endtask

  task automatic model_edge();
    bit n_off, n_busy, n_err;
    int n_idx, n_ptr, n_age;
    n_off = m_off; n_busy = m_busy; n_idx = m_idx; n_ptr = m_ptr; n_age = m_age;
    n_err = err_clr ? 1'b0 : m_err;
    if (m_busy) begin
      if (pkt_done) begin
        n_busy = 0;
        n_age  = 0;
      end else begin
        if (m_age < TMO) n_age = m_age + 1;
        if (m_age + 1 == TMO) n_err = 1;
      end
    end else if (m_off) begin
      if (addr_if.addr_ready) begin
        n_off = 0; n_busy = 1; n_ptr = m_idx;
      end
    end else if ((req_vld & req_en) != 0) begin
      n_idx = rr_search(req_vld & req_en, m_ptr);
      n_off = 1;
    end
    m_off = n_off; m_busy = n_busy; m_idx = n_idx; m_ptr = n_ptr; m_age = n_age; m_err = n_err;
  endtask

  task automatic compare();
    check_eq("addr_valid", 32'(addr_if.addr_valid), 32'(m_off));
    check_eq("addr_data", 32'(addr_if.addr_data), 32'(m_idx));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare();
    rst = 1'b0;
  endtask

  task automatic wait_model_busy(input string tag);
    int n = 0;
    while (!m_busy && n < 20) begin
      step();
      n++;
    end
    if (!m_busy) check_eq(tag, 32'(0), 32'(1));
  endtask

  initial begin
    int c, n;
    logic [NSZ-1:0] rec;
    bit seen;
    rst = 1'b1; req_vld = '0; req_en = '1; pkt_done = 1'b0; err_clr = 1'b0;
    addr_if.addr_ready = 1'b1;
    do_reset();

    // Single request: offer one cycle after sampling, busy the cycle after.
    req_vld = 8'b0000_0100;
    step();
    check_eq("single_valid", 32'(addr_if.addr_valid), 32'(1));
    check_eq("single_data", 32'(addr_if.addr_data), 32'(2));
    req_vld = '0;
    step();
    check_eq("single_busy", 32'(busy), 32'(1));
    pkt_done = 1'b1; step(); pkt_done = 1'b0;

    // Rotation with all sources requesting: 0..7,0 and a single idle bubble between packets.
    do_reset();
    req_vld = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      seen = 0; rec = '0; c = 0;
      while (!seen && c < 12) begin
        step();
        if (addr_if.addr_valid) begin
          seen = 1;
          rec  = addr_if.addr_data;
        end else c++;
      end
      check_eq("rot_grant", seen ? 32'(rec) : 32'hFFFF_FFFF, 32'(g % NUM));
      check_eq("rot_gap", 32'(c), 32'(0));
      step(); step();
      pkt_done = 1'b1; step(); pkt_done = 1'b0;
      check_eq("rot_idle", 32'(busy | addr_if.addr_valid), 32'(0));
    end

    // Offer held under backpressure while the request drops.
    do_reset();
    addr_if.addr_ready = 1'b0;
    req_vld = 8'b0100_0000;
    step();
    req_vld = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_valid", 32'(addr_if.addr_valid), 32'(1));
      check_eq("hold_data", 32'(addr_if.addr_data), 32'(6));
    end
    addr_if.addr_ready = 1'b1;
    step();
    check_eq("hold_busy", 32'(busy), 32'(1));
    pkt_done = 1'b1; step(); pkt_done = 1'b0;

    // Mask restricts grants to sources 5 and 7.
    do_reset();
    req_vld = 8'hFF; req_en = 8'b1010_0000;
    for (int g = 0; g < 4; g++) begin
      wait_model_busy("mask_wait");
      check_eq("mask_grant", 32'(addr_if.addr_data), (g % 2 == 0) ? 32'(5) : 32'(7));
      step();
      pkt_done = 1'b1; step(); pkt_done = 1'b0;
    end
    req_en = '1;

    // Watchdog fires TMO cycles after BUSY entry, clears on err_clr, grant kept until pkt_done.
    do_reset();
    req_vld = 8'b0000_0001;
    wait_model_busy("wd_wait");
    req_vld = '0;
    n = 0;
    while (!timeout_err && n < 40) begin
      step();
      n++;
    end
    check_eq("wd_latency", 32'(n), 32'(TMO));
    check_eq("wd_busy", 32'(busy), 32'(1));
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check_eq("wd_clear", 32'(timeout_err), 32'(0));
    pkt_done = 1'b1; step(); pkt_done = 1'b0;
    check_eq("wd_release", 32'(busy), 32'(0));

    // Asynchronous reset mid-BUSY with the pointer at 3.
    do_reset();
    req_vld = 8'b0000_1000;
    wait_model_busy("rst_wait");
    step();
    req_vld = '0;
    rst = 1'b1;
    #2;
    check_eq("rst_valid", 32'(addr_if.addr_valid), 32'(0));
    check_eq("rst_data", 32'(addr_if.addr_data), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_err", 32'(timeout_err), 32'(0));
    model_reset();
    rst = 1'b0;
    req_vld = 8'b0001_1000;
    step();
    check_eq("rst_regrant", 32'(addr_if.addr_data), 32'(3));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      req_vld = NUM'($urandom);
      req_en  = NUM'($urandom | $urandom);
      addr_if.addr_ready = ($urandom_range(0, 2) != 0);
      pkt_done = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 7) == 0);
      err_clr  = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
